// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the memory arbiter slice
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    FLASH = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } requester_t;

  // bit positions inside the one-hot grant vector
  localparam int GNT_FETCH = 0;
  localparam int GNT_DATA  = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - loader, fetch, data and RAM command bundle of the arbiter
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             flash_en;
  logic [WIDTH-1:0] flash_addr;
  logic [WIDTH-1:0] flash_data;

  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;

  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic             busy;

  modport slave (
    input  flash_en, flash_addr, flash_data,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output flash_en, flash_addr, flash_data,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin choice, one-hot grant
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic       req_fetch,
  input  logic       req_data,
  input  requester_t last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_fetch && req_data) begin
      // contention goes to whoever was not served most recently
      if (last == REQ_DATA) gnt[GNT_FETCH] = 1'b1;
      else                  gnt[GNT_DATA]  = 1'b1;
    end else if (req_fetch) begin
      gnt[GNT_FETCH] = 1'b1;
    end else if (req_data) begin
      gnt[GNT_DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch, data and flash loader onto one single-port RAM
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t       state_q, state_d;
  requester_t       last_q, last_d;
  requester_t       owner_q, owner_d;
  logic             cmd_we_q, cmd_we_d;
  logic [WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

  logic [1:0]       rr_gnt;

  logic             if_gnt_c, if_rvalid_c, d_gnt_c, d_rvalid_c;
  logic [WIDTH-1:0] if_rdata_c, d_rdata_c;
  logic             mem_en_c, mem_we_c;
  logic [WIDTH-1:0] mem_addr_c, mem_wdata_c;

  rr_arbiter2 u_rr (
    .req_fetch (bus.if_req),
    .req_data  (bus.d_req),
    .last      (last_q),
    .gnt       (rr_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= REQ_DATA;
      owner_q     <= REQ_FETCH;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if_gnt_c    = 1'b0;
    if_rvalid_c = 1'b0;
    if_rdata_c  = '0;
    d_gnt_c     = 1'b0;
    d_rvalid_c  = 1'b0;
    d_rdata_c   = '0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    case (state_q)
      IDLE: begin
        if (bus.flash_en) begin
          // the loader write lands in the entry cycle too, so a burst loses no beat
          mem_en_c    = 1'b1;
          mem_we_c    = 1'b1;
          mem_addr_c  = bus.flash_addr;
          mem_wdata_c = bus.flash_data;
          state_d     = FLASH;
        end else if (rr_gnt[GNT_FETCH]) begin
          if_gnt_c    = 1'b1;
          owner_d     = REQ_FETCH;
          last_d      = REQ_FETCH;
          cmd_we_d    = 1'b0;
          cmd_addr_d  = bus.if_addr;
          cmd_wdata_d = '0;
          state_d     = ISSUE;
        end else if (rr_gnt[GNT_DATA]) begin
          d_gnt_c     = 1'b1;
          owner_d     = REQ_DATA;
          last_d      = REQ_DATA;
          cmd_we_d    = bus.d_we;
          cmd_addr_d  = bus.d_addr;
          cmd_wdata_d = bus.d_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_c    = 1'b1;
        mem_we_c    = cmd_we_q;
        mem_addr_c  = cmd_addr_q;
        mem_wdata_c = cmd_wdata_q;
        state_d     = cmd_we_q ? IDLE : RESP;
      end
      RESP: begin
        if (owner_q == REQ_FETCH) begin
          if_rvalid_c = 1'b1;
          if_rdata_c  = bus.mem_rdata;
        end else begin
          d_rvalid_c  = 1'b1;
          d_rdata_c   = bus.mem_rdata;
        end
        state_d = IDLE;
      end
      FLASH: begin
        if (bus.flash_en) begin
          mem_en_c    = 1'b1;
          mem_we_c    = 1'b1;
          mem_addr_c  = bus.flash_addr;
          mem_wdata_c = bus.flash_data;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // combinational paths would otherwise leak requests through while reset is held
  assign bus.if_gnt    = rst & if_gnt_c;
  assign bus.if_rvalid = rst & if_rvalid_c;
  assign bus.if_rdata  = rst ? if_rdata_c : '0;
  assign bus.d_gnt     = rst & d_gnt_c;
  assign bus.d_rvalid  = rst & d_rvalid_c;
  assign bus.d_rdata   = rst ? d_rdata_c : '0;
  assign bus.mem_en    = rst & mem_en_c;
  assign bus.mem_we    = rst & mem_we_c;
  assign bus.mem_addr  = rst ? mem_addr_c : '0;
  assign bus.mem_wdata = rst ? mem_wdata_c : '0;
  assign bus.busy      = rst & (state_q != IDLE);

endmodule
